// File: rtl/priority_decoder_accum.sv
// priority_decoder_accum: rebuilds a request bit-vector from a stream of
// encoded indices, one frame per in_last, with duplicate and range flags.
// Optional feature macro: PRIORITY_DECODER_OVERLAP_EN (accept while draining).
module priority_decoder_accum #(
    parameter  int NUM_OUTPUTS = 4,
    localparam int INDEX_WIDTH = $clog2(NUM_OUTPUTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INDEX_WIDTH-1:0] in_index,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_OUTPUTS-1:0] out_vector,
    output logic                   out_dup,
    output logic                   out_err
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [NUM_OUTPUTS-1:0] acc;
    logic                   dup_acc;
    logic                   err_acc;

    logic [NUM_OUTPUTS-1:0] onehot;
    logic                   err_beat;
    logic                   hit;
    logic                   accept;
    logic                   accept_last;
    logic                   drain;

    // Decode the incoming index; out-of-range values match no bit.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (in_index == INDEX_WIDTH'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

    // Range flag only exists when the index space exceeds the vector width.
    if (NUM_OUTPUTS < (1 << INDEX_WIDTH)) begin : g_range
        assign err_beat = (in_index > INDEX_WIDTH'(NUM_OUTPUTS - 1));
    end else begin : g_no_range
        assign err_beat = 1'b0;
    end

    assign hit       = |(acc & onehot);
    assign out_valid = (state_q == HOLD);
    assign drain     = out_valid && out_ready;

`ifdef PRIORITY_DECODER_OVERLAP_EN
    assign in_ready = !out_valid || out_ready;
`else
    assign in_ready = (state_q == ACCUM);
`endif

    assign accept      = in_valid && in_ready;
    assign accept_last = accept && in_last;

    // Next-state: a closing beat always lands in HOLD, a drain without one
    // returns to ACCUM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: begin
                if (accept_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept_last) begin
                    state_d = HOLD;
                end else if (drain) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame accumulators: merge each accepted beat, clear when a frame closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            dup_acc <= 1'b0;
            err_acc <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                acc     <= '0;
                dup_acc <= 1'b0;
                err_acc <= 1'b0;
            end else begin
                acc     <= acc | onehot;
                dup_acc <= dup_acc | hit;
                err_acc <= err_acc | err_beat;
            end
        end
    end

    // Result registers: loaded by the closing beat, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vector <= '0;
            out_dup    <= 1'b0;
            out_err    <= 1'b0;
        end else if (accept_last) begin
            out_vector <= acc | onehot;
            out_dup    <= dup_acc | hit;
            out_err    <= err_acc | err_beat;
        end
    end

endmodule

// File: tb/tb_priority_decoder_accum.sv
// tb_priority_decoder_accum: directed and random frames on a 4-wide and a
// 5-wide decoder sharing the handshake inputs, checked against a set model.
module tb_priority_decoder_accum;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [1:0] idx4;
    logic [2:0] idx5;
    logic       in_ready4;
    logic       in_ready5;
    logic       out_valid4;
    logic       out_valid5;
    logic [3:0] vec4;
    logic [4:0] vec5;
    logic       dup4;
    logic       dup5;
    logic       err4;
    logic       err5;

    int n_checks = 0;
    int n_fail   = 0;

    int         q4[$];
    int         q5[$];
    bit         pend;
    logic [4:0] ev4;
    logic [4:0] ev5;
    bit         ed4;
    bit         ed5;
    bit         ee4;
    bit         ee5;

    priority_decoder_accum #(.NUM_OUTPUTS(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_index(idx4), .in_last(in_last),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_vector(vec4), .out_dup(dup4), .out_err(err4)
    );

    priority_decoder_accum #(.NUM_OUTPUTS(5)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready5),
        .in_index(idx5), .in_last(in_last),
        .out_valid(out_valid5), .out_ready(out_ready),
        .out_vector(vec5), .out_dup(dup5), .out_err(err5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame result as a set: in-range indices become bits, a repeat of an
    // in-range index is a duplicate, any out-of-range index is an error.
    function automatic void summarize(input int q[$], input int n,
                                      output logic [4:0] v, output bit d,
                                      output bit e);
        v = '0;
        d = 1'b0;
        e = 1'b0;
        foreach (q[k]) begin
            if (q[k] >= n) begin
                e = 1'b1;
            end else begin
                if (v[q[k]]) d = 1'b1;
                v[q[k]] = 1'b1;
            end
        end
    endfunction

    task automatic model_reset();
        q4.delete();
        q5.delete();
        pend = 1'b0;
        ev4 = '0; ev5 = '0;
        ed4 = 1'b0; ed5 = 1'b0;
        ee4 = 1'b0; ee5 = 1'b0;
    endtask

    task automatic check_outputs();
        check("out_valid4", 32'(out_valid4), 32'(pend));
        check("out_vector4", 32'(vec4), 32'(ev4[3:0]));
        check("out_dup4", 32'(dup4), 32'(ed4));
        check("out_err4", 32'(err4), 32'(ee4));
        check("out_valid5", 32'(out_valid5), 32'(pend));
        check("out_vector5", 32'(vec5), 32'(ev5));
        check("out_dup5", 32'(dup5), 32'(ed5));
        check("out_err5", 32'(err5), 32'(ee5));
    endtask

    // One cycle: drive at negedge, check in_ready, update model at the edge,
    // check registered outputs at the next negedge.
    task automatic step(input bit v, input int idx, input bit last,
                        input bit ordy);
        bit exp_rdy;
        bit acc;
        bit drn;
        in_valid  = v;
        idx4      = idx[1:0];
        idx5      = idx[2:0];
        in_last   = last;
        out_ready = ordy;
        #1;
`ifdef PRIORITY_DECODER_OVERLAP_EN
        exp_rdy = !pend || ordy;
`else
        exp_rdy = !pend;
`endif
        check("in_ready4", 32'(in_ready4), 32'(exp_rdy));
        check("in_ready5", 32'(in_ready5), 32'(exp_rdy));
        acc = v && exp_rdy;
        drn = pend && ordy;
        @(posedge clk);
        if (drn) pend = 1'b0;
        if (acc) begin
            q4.push_back(idx % 4);
            q5.push_back(idx % 8);
            if (last) begin
                summarize(q4, 4, ev4, ed4, ee4);
                summarize(q5, 5, ev5, ed5, ee5);
                q4.delete();
                q5.delete();
                pend = 1'b1;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("rst_in_ready4", 32'(in_ready4), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        idx4 = '0;
        idx5 = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t1_valid", 32'(out_valid4), 32'd0);
        check("t1_ready", 32'(in_ready4), 32'd1);
        check("t1_vec", 32'(vec4), 32'h0);
        check("t1_dup", 32'(dup4), 32'd0);
        check("t1_err", 32'(err4), 32'd0);
        @(negedge clk);

        step(1, 3, 0, 1);
        step(1, 1, 0, 1);
        step(1, 0, 1, 1);
        check("t2_vec", 32'(vec4), 32'hb);
        check("t2_dup", 32'(dup4), 32'd0);
        step(0, 0, 0, 1);

        step(1, 2, 0, 1);
        step(1, 2, 1, 1);
        check("t3_vec", 32'(vec4), 32'h4);
        check("t3_dup", 32'(dup4), 32'd1);
        step(0, 0, 0, 1);
        step(1, 1, 1, 1);
        check("t3b_vec", 32'(vec4), 32'h2);
        check("t3b_dup", 32'(dup4), 32'd0);
        step(0, 0, 0, 1);

        step(1, 7, 0, 1);
        step(1, 4, 1, 1);
        check("t4_vec5", 32'(vec5), 32'h10);
        check("t4_err5", 32'(err5), 32'd1);
        step(0, 0, 0, 1);

        step(1, 3, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            check("t5_hold_vec", 32'(vec4), 32'h8);
            check("t5_hold_rdy", 32'(in_ready4), 32'd0);
        end
        step(1, 0, 1, 1);
`ifdef PRIORITY_DECODER_OVERLAP_EN
        check("t5_overlap_vec", 32'(vec4), 32'h1);
        check("t5_overlap_valid", 32'(out_valid4), 32'd1);
`endif
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        step(1, 1, 0, 1);
        do_reset();
        step(1, 2, 1, 1);
        check("t6_vec", 32'(vec4), 32'h4);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(3) != 0, int'($urandom_range(7)),
                     $urandom_range(2) == 0, $urandom_range(2) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
